// File: rtl/cdc_result_tx.sv
// cdc_result_tx: clk2-side write end of a gray-pointer async FIFO returning results to clk1
module cdc_result_tx #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = 14
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  input  logic [ASIZE:0]   rptr_gray_async,
  output logic [ASIZE:0]   wptr_gray,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [DSIZE-1:0] rd_data,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             overflow
);
  localparam logic [ASIZE:0] AF = (ASIZE+1)'(AF_THRESH);
  logic [DSIZE-1:0] mem [2**ASIZE];
  logic [ASIZE:0] wbin, rq1, rq2, rbin, wbin_nxt, wgray_nxt, lvl_nxt;
  logic acc;
  assign acc       = in_valid && !wfull;
  assign in_ready  = rst_n && !wfull;
  assign wbin_nxt  = wbin + {{ASIZE{1'b0}}, acc};
  assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);
  assign lvl_nxt   = wbin_nxt - rbin;
  assign rd_data   = mem[rd_addr];
  for (genvar i = 0; i <= ASIZE; i++) begin : g2b
    assign rbin[i] = ^rq2[ASIZE:i];
  end
  // storage write; data lands on the same edge the pointer is published, so the reader sees it settled
  always_ff @(posedge clk2)
    if (acc) mem[wbin[ASIZE-1:0]] <= in_data;
  // write pointer, read-pointer synchronizer and status flags computed from the next pointer
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      rq1          <= '0;
      rq2          <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      overflow     <= 1'b0;
    end else begin
      wbin         <= wbin_nxt;
      wptr_gray    <= wgray_nxt;
      rq1          <= rptr_gray_async;
      rq2          <= rq1;
      wfull        <= wgray_nxt == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]};
      walmost_full <= lvl_nxt >= AF;
      wlevel       <= lvl_nxt;
      overflow     <= overflow || (in_valid && wfull);
    end
endmodule
